reg_scoreboard: RTL and testbench

Hazard controller for the 5-stage pipeline's 32-entry general register file. Tracks the destination register and remaining production latency (Tnew) of every in-flight instruction in E, M and W. Compares them against the operands of the instruction in D. Drives the D-stage stall and per-operand forwarding selects, and sits alongside the D-stage decoder and the GRF.

---
 rtl/reg_scoreboard_pkg.sv | 26 ++
 rtl/reg_scoreboard_sb_src_check.sv | 65 ++++++
 rtl/reg_scoreboard.sv | 108 ++++++++++
 tb/tb_reg_scoreboard.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register-file hazard scoreboard.
//   FWD_*  : operand source select codes driven on fwd_sel0/fwd_sel1
//   TNEW_* : production latency of an instruction on entry to E
//   TUSE_* : cycles from D until an operand is consumed
//   match_t: which pipeline entry (if any) supplies a D operand
package reg_scoreboard_pkg;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;

  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] TUSE_BRANCH = 2'd0;
  localparam logic [1:0] TUSE_ALU    = 2'd1;
  localparam logic [1:0] TUSE_STORE  = 2'd2;

  typedef enum logic [1:0] {
    MATCH_NONE = 2'd0,
    MATCH_E    = 2'd1,
    MATCH_M    = 2'd2,
    MATCH_W    = 2'd3
  } match_t;

endpackage

// File: rtl/reg_scoreboard_sb_src_check.sv
// Hazard / forwarding check for one D-stage source operand.
// Ports:
//   i_valid            D holds a real instruction
//   i_src, i_tuse      operand register address and its Tuse
//   i_{e,m,w}_dst/tnew tracked in-flight entries
//   o_hazard           operand value not ready in time -> stall
//   o_fwd_sel          FWD_GRF / FWD_E / FWD_M
module sb_src_check
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned TNEW_W = 2
) (
  input  logic              i_valid,
  input  logic [4:0]        i_src,
  input  logic [TNEW_W-1:0] i_tuse,
  input  logic [4:0]        i_e_dst,
  input  logic [TNEW_W-1:0] i_e_tnew,
  input  logic [4:0]        i_m_dst,
  input  logic [TNEW_W-1:0] i_m_tnew,
  input  logic [4:0]        i_w_dst,
  input  logic [TNEW_W-1:0] i_w_tnew,
  output logic              o_hazard,
  output logic [1:0]        o_fwd_sel
);

  match_t            w_match;
  logic [TNEW_W-1:0] w_tnew;

  // Youngest producer wins. A non-zero i_src guarantees a matched dst is
  // non-zero too, so $0 entries can never match.
  always_comb begin
    w_match = MATCH_NONE;
    w_tnew  = '0;
    if (i_valid && (i_src != 5'd0)) begin
      if (i_e_dst == i_src) begin
        w_match = MATCH_E;
        w_tnew  = i_e_tnew;
      end else if (i_m_dst == i_src) begin
        w_match = MATCH_M;
        w_tnew  = i_m_tnew;
      end else if (i_w_dst == i_src) begin
        w_match = MATCH_W;
        w_tnew  = i_w_tnew;
      end
    end
  end

  // W forwards through the GRF write-through, so it keeps FWD_GRF.
  always_comb begin
    o_hazard  = 1'b0;
    o_fwd_sel = FWD_GRF;
    if (w_match != MATCH_NONE) begin
      if (w_tnew > i_tuse) begin
        o_hazard = 1'b1;
      end else if (w_tnew == '0) begin
        case (w_match)
          MATCH_E: o_fwd_sel = FWD_E;
          MATCH_M: o_fwd_sel = FWD_M;
          default: o_fwd_sel = FWD_GRF;
        endcase
      end
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Hazard controller for the 5-stage pipeline's 32-entry GRF.
// Tracks {dst, tnew} of the instructions in E, M and W and checks the
// D-stage operands against them.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   d_valid                    D holds a real instruction
//   d_src0/1, d_tuse0/1        D operand addresses and Tuse
//   d_dst, d_tnew              D destination and Tnew on entry to E
//   d_md, md_busy              mult/div structural hazard inputs
//   flush                      kill the instruction entering E
//   stall                      freeze PC and F/D, bubble into E
//   fwd_sel0/1                 operand source select
//   e_dst, m_dst, w_dst        tracked destinations
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned TNEW_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [4:0]        d_src0,
  input  logic [4:0]        d_src1,
  input  logic [TNEW_W-1:0] d_tuse0,
  input  logic [TNEW_W-1:0] d_tuse1,
  input  logic [4:0]        d_dst,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_md,
  input  logic              md_busy,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_sel0,
  output logic [1:0]        fwd_sel1,
  output logic [4:0]        e_dst,
  output logic [4:0]        m_dst,
  output logic [4:0]        w_dst
);

  logic [4:0]        r_e_dst, r_m_dst, r_w_dst;
  logic [TNEW_W-1:0] r_e_tnew, r_m_tnew, r_w_tnew;
  logic              w_hazard0, w_hazard1, w_stall, w_e_load;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  sb_src_check #(.TNEW_W(TNEW_W)) u_chk0 (
    .i_valid  (d_valid),
    .i_src    (d_src0),
    .i_tuse   (d_tuse0),
    .i_e_dst  (r_e_dst),
    .i_e_tnew (r_e_tnew),
    .i_m_dst  (r_m_dst),
    .i_m_tnew (r_m_tnew),
    .i_w_dst  (r_w_dst),
    .i_w_tnew (r_w_tnew),
    .o_hazard (w_hazard0),
    .o_fwd_sel(fwd_sel0)
  );

  sb_src_check #(.TNEW_W(TNEW_W)) u_chk1 (
    .i_valid  (d_valid),
    .i_src    (d_src1),
    .i_tuse   (d_tuse1),
    .i_e_dst  (r_e_dst),
    .i_e_tnew (r_e_tnew),
    .i_m_dst  (r_m_dst),
    .i_m_tnew (r_m_tnew),
    .i_w_dst  (r_w_dst),
    .i_w_tnew (r_w_tnew),
    .o_hazard (w_hazard1),
    .o_fwd_sel(fwd_sel1)
  );

  assign w_stall  = w_hazard0 | w_hazard1 | (d_valid & d_md & md_busy);
  assign w_e_load = d_valid & ~w_stall & ~flush;

  // The pipeline behind D never freezes; Tnew counts down on every hop so
  // a load has fully resolved by the time it reaches W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_dst  <= '0;
      r_e_tnew <= '0;
      r_m_dst  <= '0;
      r_m_tnew <= '0;
      r_w_dst  <= '0;
      r_w_tnew <= '0;
    end else begin
      r_w_dst  <= r_m_dst;
      r_w_tnew <= sat_dec(r_m_tnew);
      r_m_dst  <= r_e_dst;
      r_m_tnew <= sat_dec(r_e_tnew);
      if (w_e_load) begin
        r_e_dst  <= d_dst;
        r_e_tnew <= d_tnew;
      end else begin
        r_e_dst  <= '0;
        r_e_tnew <= '0;
      end
    end
  end

  assign stall = w_stall;
  assign e_dst = r_e_dst;
  assign m_dst = r_m_dst;
  assign w_dst = r_w_dst;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_src0, d_src1, d_dst;
  logic [1:0] d_tuse0, d_tuse1, d_tnew;
  logic       d_md, md_busy, flush;
  logic       stall;
  logic [1:0] fwd_sel0, fwd_sel1;
  logic [4:0] e_dst, m_dst, w_dst;

  reg_scoreboard #(.TNEW_W(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .d_valid (d_valid),
    .d_src0  (d_src0),
    .d_src1  (d_src1),
    .d_tuse0 (d_tuse0),
    .d_tuse1 (d_tuse1),
    .d_dst   (d_dst),
    .d_tnew  (d_tnew),
    .d_md    (d_md),
    .md_busy (md_busy),
    .flush   (flush),
    .stall   (stall),
    .fwd_sel0(fwd_sel0),
    .fwd_sel1(fwd_sel1),
    .e_dst   (e_dst),
    .m_dst   (m_dst),
    .w_dst   (w_dst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       st;
    logic [1:0] f0;
    logic [1:0] f1;
    logic [4:0] e;
    logic [4:0] m;
    logic [4:0] w;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  exp;
  } item_t;

  item_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Monitor: one expectation per stimulus cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      item_t it;
      obs_t  act;
      it  = exp_q.pop_front();
      act = '{st: stall, f0: fwd_sel0, f1: fwd_sel1, e: e_dst, m: m_dst, w: w_dst};
      n_cmp++;
      if (act !== it.exp) begin
        n_bad++;
        $display("FAIL %s: got stall=%0b fwd0=%0d fwd1=%0d e=%0d m=%0d w=%0d, want stall=%0b fwd0=%0d fwd1=%0d e=%0d m=%0d w=%0d",
                 it.nm, act.st, act.f0, act.f1, act.e, act.m, act.w,
                 it.exp.st, it.exp.f0, it.exp.f1, it.exp.e, it.exp.m, it.exp.w);
      end
    end
  end

  // Drive D-stage inputs for one cycle and queue the expected response.
  task automatic step(input string nm, input bit rst, input bit v,
                      input logic [4:0] s0, input logic [1:0] u0,
                      input logic [4:0] s1, input logic [1:0] u1,
                      input logic [4:0] dst, input logic [1:0] tn,
                      input bit md, input bit busy, input bit fl,
                      input bit x_st, input logic [1:0] x_f0, input logic [1:0] x_f1,
                      input logic [4:0] x_e, input logic [4:0] x_m, input logic [4:0] x_w);
    item_t it;
    @(posedge clk);
    #1;
    reset   = rst;
    d_valid = v;
    d_src0  = s0;
    d_tuse0 = u0;
    d_src1  = s1;
    d_tuse1 = u1;
    d_dst   = dst;
    d_tnew  = tn;
    d_md    = md;
    md_busy = busy;
    flush   = fl;
    it.nm   = nm;
    it.exp  = '{st: x_st, f0: x_f0, f1: x_f1, e: x_e, m: x_m, w: x_w};
    exp_q.push_back(it);
  endtask

  // Reset cycle whose own outputs depend on prior state: not checked.
  task automatic go_reset();
    @(posedge clk);
    #1;
    reset   = 1'b1;
    d_valid = 1'b0;
    d_md    = 1'b0;
    md_busy = 1'b0;
    flush   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; d_valid = 1'b0; d_src0 = '0; d_src1 = '0; d_tuse0 = '0;
    d_tuse1 = '0; d_dst = '0; d_tnew = '0; d_md = 1'b0; md_busy = 1'b0; flush = 1'b0;

    //        name         rst v  s0 u0 s1 u1 dst tn md bz fl | st f0 f1 e  m  w
    step("reset_state",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    // load-use, consumer Tuse=1
    step("lw1_issue",      0, 1, 0, 0, 0, 0, 1, TNEW_LOAD, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step("loaduse_stall",  0, 1, 1, TUSE_ALU, 0, 0, 6, TNEW_ALU, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    step("loaduse_clear",  0, 1, 1, TUSE_ALU, 0, 0, 6, TNEW_ALU, 0, 0, 0,  0, 0, 0, 0, 1, 0);
    step("loaduse_adv",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 6, 0, 1);
    step("fwd_from_m",     0, 1, 6, TUSE_BRANCH, 0, 0, 0, 0, 0, 0, 0,  0, FWD_M, 0, 0, 6, 0);
    step("w_via_grf",      0, 1, 0, 0, 6, TUSE_BRANCH, 0, 0, 0, 0, 0,  0, 0, FWD_GRF, 0, 0, 6);

    // branch after ALU, then branch after load
    go_reset();
    step("alu2_issue",     0, 1, 0, 0, 0, 0, 2, TNEW_ALU, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step("br_alu_stall",   0, 1, 2, TUSE_BRANCH, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2, 0, 0);
    step("br_alu_fwdm",    0, 1, 2, TUSE_BRANCH, 0, 0, 0, 0, 0, 0, 0,  0, FWD_M, 0, 0, 2, 0);
    step("lw3_issue",      0, 1, 0, 0, 0, 0, 3, TNEW_LOAD, 0, 0, 0,  0, 0, 0, 0, 0, 2);
    step("br_lw_stall1",   0, 1, 0, 0, 3, TUSE_BRANCH, 0, 0, 0, 0, 0,  1, 0, 0, 3, 0, 0);
    step("br_lw_stall2",   0, 1, 0, 0, 3, TUSE_BRANCH, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3, 0);
    step("br_lw_release",  0, 1, 0, 0, 3, TUSE_BRANCH, 0, 0, 0, 0, 0,  0, 0, FWD_GRF, 0, 0, 3);

    // back-to-back ALU, lui-class forwarding from E, $0 destination
    go_reset();
    step("alu3_issue",     0, 1, 0, 0, 0, 0, 3, TNEW_ALU, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step("b2b_alu",        0, 1, 3, TUSE_ALU, 3, TUSE_ALU, 7, TNEW_ALU, 0, 0, 0,  0, 0, 0, 3, 0, 0);
    step("lui4_issue",     0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0,  0, 0, 0, 7, 3, 0);
    step("fwd_e_and_m",    0, 1, 4, TUSE_ALU, 7, TUSE_ALU, 0, 0, 0, 0, 0,  0, FWD_E, FWD_M, 4, 7, 3);
    step("zero_dst_issue", 0, 1, 0, 0, 0, 0, 0, TNEW_ALU, 0, 0, 0,  0, 0, 0, 0, 4, 7);
    step("zero_src_read",  0, 1, 0, TUSE_BRANCH, 0, TUSE_BRANCH, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4);

    // double write (E wins), mult/div busy
    go_reset();
    step("lw4_issue",      0, 1, 0, 0, 0, 0, 4, TNEW_LOAD, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step("lui4_again",     0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0,  0, 0, 0, 4, 0, 0);
    step("dbl_write_e",    0, 1, 4, TUSE_BRANCH, 4, TUSE_STORE, 0, 0, 0, 0, 0,  0, FWD_E, FWD_E, 4, 4, 0);
    step("md_busy1",       0, 1, 0, 0, 0, 0, 8, TNEW_ALU, 1, 1, 0,  1, 0, 0, 0, 4, 4);
    step("md_busy2",       0, 1, 0, 0, 0, 0, 8, TNEW_ALU, 1, 1, 0,  1, 0, 0, 0, 0, 4);
    step("md_free",        0, 1, 0, 0, 0, 0, 8, TNEW_ALU, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    step("md_bubble",      0, 0, 0, 0, 0, 0, 8, TNEW_ALU, 1, 1, 0,  0, 0, 0, 8, 0, 0);

    // reset mid-stall, flush
    go_reset();
    step("lw5_issue",      0, 1, 0, 0, 0, 0, 5, TNEW_LOAD, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step("lw5_use_stall",  0, 1, 5, TUSE_BRANCH, 0, 0, 9, TNEW_ALU, 0, 0, 0,  1, 0, 0, 5, 0, 0);
    step("reset_in_stall", 1, 1, 5, TUSE_BRANCH, 0, 0, 9, TNEW_ALU, 0, 0, 0,  1, 0, 0, 0, 5, 0);
    step("after_reset",    1, 1, 0, 0, 0, 0, 9, TNEW_LOAD, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step("reset_no_load",  0, 1, 0, 0, 0, 0, 10, TNEW_ALU, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    step("flush_bubble",   0, 1, 0, 0, 0, 0, 11, TNEW_LOAD, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step("flush_stall",    0, 1, 11, TUSE_ALU, 0, 0, 12, TNEW_ALU, 0, 0, 1,  1, 0, 0, 11, 0, 0);
    step("flush_adv",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 11, 0);

    // let the monitor drain, bounded
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
